// File: rtl/countdown_timer.sv
// Two-digit BCD round-clock countdown timer: loads a start value, counts down on
// each tick, supports pause toggle, saturating bonus time and expiry reporting.
module countdown_timer #(
    parameter logic [7:0] START_BCD = 8'h60,
    parameter logic [7:0] BONUS_BCD = 8'h05,
    parameter logic [7:0] WARN_BCD  = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       bonus,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       paused,
    output logic       expired,
    output logic       done,
    output logic       warn
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] value_r;
    logic [7:0] value_s;
    logic       done_r;
    logic       done_s;
    logic [7:0] sum_s;
    logic [7:0] dec_tick_s;
    logic [7:0] dec_both_s;

    // Packed-BCD add with decimal carry; any result above 99 saturates to 99.
    function automatic logic [7:0] bcd_add_sat(input logic [7:0] a, input logic [7:0] b);
        logic [4:0] o;
        logic [4:0] t;
        logic [7:0] r;
        o = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        t = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        if (o > 5'd9) begin
            o = o - 5'd10;
            t = t + 5'd1;
        end else begin
            o = o;
        end
        if (t > 5'd9) begin
            r = 8'h99;
        end else begin
            r = {t[3:0], o[3:0]};
        end
        return r;
    endfunction

    // Packed-BCD decrement by one with borrow, clamped at 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] a);
        logic [7:0] r;
        if (a == 8'h00) begin
            r = 8'h00;
        end else if (a[3:0] == 4'd0) begin
            r = {a[7:4] - 4'd1, 4'd9};
        end else begin
            r = {a[7:4], a[3:0] - 4'd1};
        end
        return r;
    endfunction

    assign sum_s      = bcd_add_sat(value_r, BONUS_BCD);
    assign dec_tick_s = bcd_dec(value_r);
    assign dec_both_s = bcd_dec(sum_s);

    // Next-state and next-value logic; start beats pause beats tick/bonus.
    always_comb begin
        state_s = state_r;
        value_s = value_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                state_s = start ? RUN : IDLE;
                value_s = START_BCD;
            end
            RUN: begin
                if (start) begin
                    value_s = START_BCD;
                end else if (pause) begin
                    state_s = PAUSE;
                end else if (tick && bonus) begin
                    value_s = dec_both_s;
                    state_s = (dec_both_s == 8'h00) ? DONE : RUN;
                end else if (tick) begin
                    value_s = dec_tick_s;
                    state_s = (dec_tick_s == 8'h00) ? DONE : RUN;
                end else if (bonus) begin
                    value_s = sum_s;
                end else begin
                    value_s = value_r;
                end
            end
            PAUSE: begin
                if (start) begin
                    state_s = RUN;
                    value_s = START_BCD;
                end else if (pause) begin
                    state_s = RUN;
                end else if (bonus) begin
                    value_s = sum_s;
                end else begin
                    value_s = value_r;
                end
            end
            DONE: begin
                if (start) begin
                    state_s = RUN;
                    value_s = START_BCD;
                end else begin
                    value_s = 8'h00;
                end
            end
            default: begin
                state_s = IDLE;
                value_s = START_BCD;
            end
        endcase
        if ((state_s == DONE) && (state_r != DONE)) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // State, value and done-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            value_r <= START_BCD;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            value_r <= value_s;
            done_r  <= done_s;
        end
    end

    assign tens    = value_r[7:4];
    assign ones    = value_r[3:0];
    assign running = (state_r == RUN);
    assign paused  = (state_r == PAUSE);
    assign expired = (state_r == DONE);
    assign done    = done_r;
    // Valid BCD orders the same as binary, so a plain compare is a BCD compare.
    assign warn    = ((state_r == RUN) || (state_r == PAUSE)) && (value_r <= WARN_BCD);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with default parameters.
module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic       pause;
    logic       bonus;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       paused;
    logic       expired;
    logic       done;
    logic       warn;

    int tests_run;
    int tests_failed;

    countdown_timer dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .start   (start),
        .pause   (pause),
        .bonus   (bonus),
        .tens    (tens),
        .ones    (ones),
        .running (running),
        .paused  (paused),
        .expired (expired),
        .done    (done),
        .warn    (warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; returns #1 after the edge so outputs are settled.
    task automatic cyc(input logic s, input logic p, input logic t, input logic b);
        start = s;
        pause = p;
        tick  = t;
        bonus = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        tick  = 1'b0;
        bonus = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    function automatic logic [31:0] val();
        return {24'd0, tens, ones};
    endfunction

    function automatic logic [31:0] flags();
        return {27'd0, running, paused, expired, done, warn};
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        tick  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        bonus = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_value", val(), 32'h60);
        check("reset_flags", flags(), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // IDLE ignores tick
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_tick_value", val(), 32'h60);
        check("idle_tick_flags", flags(), 32'h0);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_value", val(), 32'h60);
        check("start_flags", flags(), 32'h10);
        tick_n(1);
        check("borrow_59", val(), 32'h59);
        check("run_after_tick", {31'd0, running}, 32'h1);

        tick_n(17);
        check("reach_42", val(), 32'h42);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_flags", flags(), 32'h08);
        tick_n(5);
        check("pause_hold_42", val(), 32'h42);
        check("pause_still", {31'd0, paused}, 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(1);
        check("resume_41", val(), 32'h41);
        check("resume_running", {31'd0, running}, 32'h1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("pause_tick_value", val(), 32'h41);
        check("pause_tick_flags", flags(), 32'h08);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);

        tick_n(3);
        check("reach_38", val(), 32'h38);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("bonus_43", val(), 32'h43);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("pause_bonus_48", val(), 32'h48);
        check("pause_bonus_flags", flags(), 32'h08);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("bonus_98", val(), 32'h98);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_from_98", val(), 32'h99);
        tick_n(2);
        check("reach_97", val(), 32'h97);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_from_97", val(), 32'h99);

        tick_n(88);
        check("reach_11", val(), 32'h11);
        check("warn_at_11", {31'd0, warn}, 32'h0);
        tick_n(1);
        check("reach_10", val(), 32'h10);
        check("warn_at_10", {31'd0, warn}, 32'h1);
        tick_n(1);
        check("borrow_09", val(), 32'h09);
        tick_n(8);
        check("reach_01", val(), 32'h01);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("tick_bonus_05", val(), 32'h05);
        check("tick_bonus_flags", flags(), 32'h11);

        tick_n(2);
        check("reach_03", val(), 32'h03);
        tick_n(1);
        check("expiry_02", val(), 32'h02);
        tick_n(1);
        check("expiry_01", val(), 32'h01);
        tick_n(1);
        check("expiry_00", val(), 32'h00);
        check("expiry_flags", flags(), 32'h06);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("done_one_cycle", flags(), 32'h04);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("done_tick_value", val(), 32'h00);
        check("done_no_repulse", flags(), 32'h04);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("done_ignore_value", val(), 32'h00);
        check("done_ignore_flags", flags(), 32'h04);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_value", val(), 32'h60);
        check("restart_flags", flags(), 32'h10);

        tick_n(33);
        check("reach_27", val(), 32'h27);
        tick  = 1'b1;
        reset = 1'b1;
        #1;
        check("async_reset_value", val(), 32'h60);
        check("async_reset_flags", flags(), 32'h0);
        @(posedge clk);
        #1;
        tick  = 1'b0;
        reset = 1'b0;
        tick_n(3);
        check("post_reset_value", val(), 32'h60);
        check("post_reset_flags", flags(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Two-digit BCD countdown timer for the whack-a-mole round clock. It is the down-counting counterpart of the prescaler up-counter: it consumes that counter's one-cycle terminal-count pulse as its `tick`, and counts seconds down from a loaded start value to zero. It drives the seven-segment digit decoders and tells the game controller when the round has expired, and it supports start/restart, pause toggle and bonus-time insertion.

## Interface
Parameters:
- `START_BCD`, default 8'h60: round length in packed BCD (tens in [7:4], ones in [3:0]). Legal range 8'h01..8'h99, each nibble 0-9.
- `BONUS_BCD`, default 8'h05: seconds added per `bonus` pulse, packed BCD. Legal range 8'h00..8'h99.
- `WARN_BCD`, default 8'h10: `warn` asserts at or below this value, packed BCD.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `tick`  in  1  one-cycle pulse, one per second
- `start`  in  1  one-cycle pulse: load `START_BCD` and run
- `pause`  in  1  one-cycle pulse: toggle RUN/PAUSE
- `bonus`  in  1  one-cycle pulse: add `BONUS_BCD`
- `tens`  out  4  BCD tens digit (registered)
- `ones`  out  4  BCD ones digit (registered)
- `running`  out  1  high in RUN
- `paused`  out  1  high in PAUSE
- `expired`  out  1  high in DONE (level)
- `done`  out  1  one-cycle pulse on entry to DONE
- `warn`  out  1  high in RUN/PAUSE when value ≤ `WARN_BCD`

## Operation
- All inputs are synchronous to `clk` and already debounced and pulse-shaped.
- States: IDLE, RUN, PAUSE, DONE. `running`, `paused` and `expired` decode the state directly.
- Input priority each cycle: `start` > `pause` > {`tick`, `bonus`}.
- IDLE: value = `START_BCD`. `start` → RUN, value reloaded. All other inputs are ignored.
- RUN:
  - `start` reloads `START_BCD` and stays in RUN.
  - `pause` → PAUSE. A `tick` or `bonus` in the same cycle is dropped.
  - `tick` alone: value decrements by 1 in BCD. A ones digit of 0 borrows: it becomes 9 and tens decrements. If the result is 00, go to DONE.
  - `bonus` alone: value = min(99, value + `BONUS_BCD`). BCD add with decimal carry, saturating at 99.
  - `tick` and `bonus` together: value = min(99, value + `BONUS_BCD`) − 1. Go to DONE only if the result is 00.
- PAUSE:
  - `tick` is ignored.
  - `bonus` applies exactly as in RUN.
  - `pause` → RUN.
  - `start` reloads and → RUN.
- DONE:
  - Value is held at 00.
  - `pause`, `tick` and `bonus` are ignored.
  - `start` reloads and → RUN.
- `warn` is a BCD magnitude compare of value against `WARN_BCD`, gated to RUN/PAUSE. It is 0 in IDLE and DONE.
- The value never underflows below 00 and never exceeds 99. The digits are always valid BCD.

## Timing
- Reset values:
  - state IDLE
  - `tens`/`ones` = `START_BCD`
  - `running`, `paused`, `expired`, `done`, `warn` = 0
- Latency: an input sampled at edge N is reflected on the digits and state outputs after edge N (one cycle).
- `done` rises at the same edge that enters DONE and stays high for exactly one cycle. It does not re-pulse while the block sits in DONE.
- `expired` rises together with `done` and stays high until the `start` edge. It falls at that edge, at the same time `running` rises.
- `warn` is combinational from the registered value and state, so it has no added latency beyond the value update.
- Back-to-back `tick` pulses on consecutive cycles are each honoured; there is no minimum spacing.
- Asserting `reset` mid-count returns the block to IDLE with `START_BCD` shown. If `done` is high at that moment, it is cleared immediately.

## Test plan
- **Reset and start, default parameters:** reset → digits 6,0, IDLE. Pulse `start`, then one `tick` → digits 5,9 (BCD borrow), `running`=1.
- **Full expiry:** from 8'h03 in RUN, apply 3 ticks → 02, 01, 00. `done` pulses exactly one cycle at 00, and `expired` holds. A further `tick` leaves 00 and produces no new `done`.
- **Pause:**
  - RUN at 8'h42, pulse `pause`, apply 5 ticks → still 42 with `paused`=1.
  - `pause` again plus one `tick` → 41.
  - `pause` and `tick` in the same cycle from RUN → PAUSE at 41.
- **Bonus and saturation:**
  - 8'h97 + `bonus` (05) → 99.
  - 8'h38 + `bonus` → 43.
  - 8'h01 with `tick` and `bonus` together → 05, no `done`.
- **Warn and restart:**
  - Count from 11 → 10: `warn` rises at 10.
  - In DONE, `start` → 60 with `warn`=0, `expired`=0, `running`=1.
- **Reset mid-run:** assert `reset` at value 8'h27 in RUN during a `tick` → IDLE, digits 6,0, all flags 0. Release → ticks are ignored until `start`.
